// File: rtl/mips_ctrl_defs.sv
// rtl/mips_ctrl_defs.sv - shared opcode, state and datapath select codes for the multicycle MIPS core
// Used by the control FSM, the instruction decoder and the datapath muxes.
package mips_ctrl_defs;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // FSM state encodings (also shown on state_o)
    localparam logic [3:0] S_FETCH = 4'd0;
    localparam logic [3:0] S_DCD   = 4'd1;
    localparam logic [3:0] S_MA    = 4'd2;
    localparam logic [3:0] S_MR    = 4'd3;
    localparam logic [3:0] S_MWB   = 4'd4;
    localparam logic [3:0] S_MW    = 4'd5;
    localparam logic [3:0] S_EXE   = 4'd6;
    localparam logic [3:0] S_AWB   = 4'd7;
    localparam logic [3:0] S_BR    = 4'd8;
    localparam logic [3:0] S_JMP   = 4'd9;

    // Next-PC source
    localparam logic [1:0] NPC_PC4 = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    // Register-file write address
    localparam logic [1:0] GPR_RT = 2'd0;
    localparam logic [1:0] GPR_RD = 2'd1;
    localparam logic [1:0] GPR_RA = 2'd2;

    // Register-file write data
    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    // Immediate extension
    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    // ALU operation
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    typedef enum logic [3:0] {
        C_RALU, C_IALU, C_LOAD, C_STORE, C_BEQ, C_JMP, C_JAL, C_JR, C_ILL
    } iclass_e;

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational op/funct decoder for the multicycle MIPS control FSM
// Ports: op, funct (in, from IR); iclass (instruction class), alu_op, ext_op (out).
module mips_ctrl_decode
    import mips_ctrl_defs::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_e    iclass,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op
);

    always_comb begin
        iclass = C_ILL;
        alu_op = ALU_ADD;
        ext_op = EXT_ZERO;
        case (op)
            OP_RTYPE: begin
                iclass = C_RALU;
                case (funct)
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_JR:   iclass = C_JR;
                    default: iclass = C_ILL;
                endcase
            end
            OP_ADDIU: begin iclass = C_IALU; ext_op = EXT_SIGN; end
            OP_ORI:   begin iclass = C_IALU; alu_op = ALU_OR; end
            OP_LUI:   begin iclass = C_IALU; ext_op = EXT_LUI; end
            OP_LW:    begin iclass = C_LOAD;  ext_op = EXT_SIGN; end
            OP_SW:    begin iclass = C_STORE; ext_op = EXT_SIGN; end
            OP_BEQ:   begin iclass = C_BEQ;   alu_op = ALU_SUB; end
            OP_J:     iclass = C_JMP;
            OP_JAL:   iclass = C_JAL;
            default:  iclass = C_ILL;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - main control FSM of the multicycle MIPS core
// Steps the shared datapath through fetch/decode/execute/memory/writeback and drives
// every write enable and mux select. Inputs: clk, rst_in (async active-low), op, funct,
// zero, mem_ready. Outputs: pc_wr, ir_wr, npc_op, rf_wr, gpr_sel, wd_sel, bsel, ext_op,
// alu_op, dm_wr, illegal, state_o. Optional macro MIPS_MEM_WAIT_EN makes FETCH, MR and
// MW hold until mem_ready = 1; otherwise mem_ready is ignored.
module mips_mc_ctrl
    import mips_ctrl_defs::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic [1:0] npc_op,
    output logic       rf_wr,
    output logic [1:0] gpr_sel,
    output logic [1:0] wd_sel,
    output logic       bsel,
    output logic [1:0] ext_op,
    output logic [2:0] alu_op,
    output logic       dm_wr,
    output logic       illegal,
    output logic [3:0] state_o
);

    logic [3:0] state, next_state;
    iclass_e    iclass;
    logic [2:0] dec_alu;
    logic [1:0] dec_ext;
    logic       mem_go;

`ifdef MIPS_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
`endif

    mips_ctrl_decode u_decode (
        .op     (op),
        .funct  (funct),
        .iclass (iclass),
        .alu_op (dec_alu),
        .ext_op (dec_ext)
    );

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) state <= RESET_STATE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = mem_go ? S_DCD : S_FETCH;
            S_DCD: begin
                case (iclass)
                    C_LOAD, C_STORE:      next_state = S_MA;
                    C_RALU, C_IALU:       next_state = S_EXE;
                    C_BEQ:                next_state = S_BR;
                    C_JMP, C_JAL, C_JR:   next_state = S_JMP;
                    default:              next_state = S_FETCH;
                endcase
            end
            S_MA:    next_state = (iclass == C_LOAD) ? S_MR : S_MW;
            S_MR:    next_state = mem_go ? S_MWB : S_MR;
            S_MW:    next_state = mem_go ? S_FETCH : S_MW;
            S_EXE:   next_state = S_AWB;
            default: next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pc_wr   = 1'b0;
        ir_wr   = 1'b0;
        npc_op  = NPC_PC4;
        rf_wr   = 1'b0;
        gpr_sel = GPR_RT;
        wd_sel  = WD_ALU;
        bsel    = 1'b0;
        ext_op  = EXT_ZERO;
        alu_op  = ALU_ADD;
        dm_wr   = 1'b0;
        illegal = 1'b0;
        case (state)
            S_FETCH: begin
                pc_wr = mem_go;
                ir_wr = mem_go;
            end
            S_DCD:   illegal = (iclass == C_ILL);
            S_MA: begin
                bsel   = 1'b1;
                ext_op = EXT_SIGN;
            end
            S_MW:    dm_wr = 1'b1;
            S_MWB: begin
                rf_wr  = 1'b1;
                wd_sel = WD_MEM;
            end
            S_EXE: begin
                bsel   = (iclass == C_IALU);
                alu_op = dec_alu;
                ext_op = dec_ext;
            end
            S_AWB: begin
                rf_wr   = 1'b1;
                gpr_sel = (iclass == C_RALU) ? GPR_RD : GPR_RT;
            end
            S_BR: begin
                alu_op = ALU_SUB;
                npc_op = NPC_BR;
                pc_wr  = zero;
            end
            S_JMP: begin
                pc_wr  = 1'b1;
                npc_op = (iclass == C_JR) ? NPC_JR : NPC_J;
                // PC still holds PC+4 here, so it is the jal return address.
                if (iclass == C_JAL) begin
                    rf_wr   = 1'b1;
                    gpr_sel = GPR_RA;
                    wd_sel  = WD_PC;
                end
            end
            default: ;
        endcase
        // Enables are forced low while reset is held so nothing writes during abort.
        if (!rst_in) begin
            pc_wr   = 1'b0;
            ir_wr   = 1'b0;
            rf_wr   = 1'b0;
            dm_wr   = 1'b0;
            illegal = 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - self-checking scoreboard bench for mips_mc_ctrl
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_in;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_wr, ir_wr, rf_wr, bsel, dm_wr, illegal;
    logic [1:0] npc_op, gpr_sel, wd_sel, ext_op;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;
    logic [20:0] sb[$];

    mips_mc_ctrl dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_wr     (pc_wr),
        .ir_wr     (ir_wr),
        .npc_op    (npc_op),
        .rf_wr     (rf_wr),
        .gpr_sel   (gpr_sel),
        .wd_sel    (wd_sel),
        .bsel      (bsel),
        .ext_op    (ext_op),
        .alu_op    (alu_op),
        .dm_wr     (dm_wr),
        .illegal   (illegal),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    logic [20:0] obs;
    assign obs = {state_o, pc_wr, ir_wr, npc_op, rf_wr, gpr_sel, wd_sel,
                  bsel, ext_op, alu_op, dm_wr, illegal};

    function automatic logic [20:0] ev(input int st, input int pw, input int iw, input int npc,
                                       input int rf, input int gpr, input int wd, input int bs,
                                       input int ext, input int alu, input int dm, input int ill);
        logic [3:0] s4; logic [1:0] n2, g2, w2, e2; logic [2:0] a3;
        s4 = 4'(st); n2 = 2'(npc); g2 = 2'(gpr); w2 = 2'(wd); e2 = 2'(ext); a3 = 3'(alu);
        return {s4, 1'(pw), 1'(iw), n2, 1'(rf), g2, w2, 1'(bs), e2, a3, 1'(dm), 1'(ill)};
    endfunction

    // Pushes the expected per-cycle outputs for one instruction, then checks them as the DUT steps.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input string name);
        logic [20:0] e;
        int cyc;
        op = o; funct = f; zero = z;
        sb.push_back(ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (o == 6'h00 && f != 6'h08) begin
            int alu;
            alu = (f == 6'h21) ? 0 : (f == 6'h23) ? 1 : (f == 6'h24) ? 2 :
                  (f == 6'h25) ? 3 : (f == 6'h2A) ? 4 : -1;
            if (alu < 0) sb.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            else begin
                sb.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                sb.push_back(ev(6, 0, 0, 0, 0, 0, 0, 0, 0, alu, 0, 0));
                sb.push_back(ev(7, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
            end
        end else begin
            sb.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (o inside {6'h00, 6'h09, 6'h0D, 6'h0F,
                6'h23, 6'h2B, 6'h04, 6'h02, 6'h03}) ? 0 : 1));
            case (o)
                6'h00: sb.push_back(ev(9, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
                6'h09: begin
                    sb.push_back(ev(6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
                    sb.push_back(ev(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
                end
                6'h0D: begin
                    sb.push_back(ev(6, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0));
                    sb.push_back(ev(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
                end
                6'h0F: begin
                    sb.push_back(ev(6, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
                    sb.push_back(ev(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
                end
                6'h23: begin
                    sb.push_back(ev(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
                    sb.push_back(ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                    sb.push_back(ev(4, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
                end
                6'h2B: begin
                    sb.push_back(ev(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
                    sb.push_back(ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
                end
                6'h04: sb.push_back(ev(8, z, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
                6'h02: sb.push_back(ev(9, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
                6'h03: sb.push_back(ev(9, 1, 0, 2, 1, 2, 2, 0, 0, 0, 0, 0));
                default: ;
            endcase
        end
        cyc = 0;
        while (sb.size() > 0) begin
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, obs, e);
            end
            cyc++;
            @(negedge clk);
        end
        // Next instruction must begin in FETCH (checks the latency ended exactly here).
        #1;
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL %s end_state: got %0d expected 0", name, state_o);
        end
        @(negedge clk);
        // That extra FETCH cycle consumed a fetch; let it step through a j to realign.
        sb.delete();
        op = 6'h02;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_in = 1'b0; op = 6'h23; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++;
        if ({pc_wr, ir_wr, rf_wr, dm_wr, illegal} !== 5'b0) begin
            errors++;
            $display("FAIL reset_enables: got %b expected 00000", {pc_wr, ir_wr, rf_wr, dm_wr, illegal});
        end
        @(negedge clk);
        rst_in = 1'b1;
    endtask

    task automatic test_alu();
        run_instr(6'h00, 6'h21, 1'b0, "addu");
        run_instr(6'h00, 6'h23, 1'b0, "subu");
        run_instr(6'h00, 6'h24, 1'b1, "and");
        run_instr(6'h00, 6'h25, 1'b0, "or");
        run_instr(6'h00, 6'h2A, 1'b0, "slt");
    endtask

    task automatic test_imm();
        run_instr(6'h09, 6'h3F, 1'b0, "addiu");
        run_instr(6'h0D, 6'h00, 1'b0, "ori");
        run_instr(6'h0F, 6'h21, 1'b0, "lui");
    endtask

    task automatic test_mem();
        run_instr(6'h23, 6'h00, 1'b0, "lw");
        run_instr(6'h2B, 6'h00, 1'b0, "sw");
    endtask

    task automatic test_branch();
        run_instr(6'h04, 6'h00, 1'b1, "beq_taken");
        run_instr(6'h04, 6'h00, 1'b0, "beq_not_taken");
    endtask

    task automatic test_jump();
        run_instr(6'h02, 6'h00, 1'b0, "j");
        run_instr(6'h03, 6'h00, 1'b0, "jal");
        run_instr(6'h00, 6'h08, 1'b0, "jr");
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 6'h00, 1'b0, "illegal_op");
        run_instr(6'h00, 6'h00, 1'b0, "illegal_funct");
    endtask

    task automatic test_reset_mid_mw();
        op = 6'h2B; funct = 6'h00;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd5 || dm_wr !== 1'b1) begin
            errors++;
            $display("FAIL mw_before_reset: got state %0d dm_wr %b expected 5 1", state_o, dm_wr);
        end
        rst_in = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0 || dm_wr !== 1'b0) begin
            errors++;
            $display("FAIL mw_abort: got state %0d dm_wr %b expected 0 0", state_o, dm_wr);
        end
        @(negedge clk);
        rst_in = 1'b1;
    endtask

`ifdef MIPS_MEM_WAIT_EN
    task automatic test_mem_wait();
        op = 6'h00; funct = 6'h21; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state_o !== 4'd0 || ir_wr !== 1'b0 || pc_wr !== 1'b0) begin
                errors++;
                $display("FAIL fetch_wait%0d: got state %0d ir_wr %b expected 0 0", i, state_o, ir_wr);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ir_wr !== 1'b1 || pc_wr !== 1'b1) begin
            errors++; $display("FAIL fetch_ready: got ir_wr %b expected 1", ir_wr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd1) begin errors++; $display("FAIL fetch_to_dcd: got %0d expected 1", state_o); end
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_alu();
        test_imm();
        test_mem();
        test_branch();
        test_jump();
        test_illegal();
        test_reset_mid_mw();
        run_instr(6'h00, 6'h21, 1'b0, "addu_after_abort");
`ifdef MIPS_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Main control FSM of the multicycle MIPS core. It decodes the latched instruction's opcode/funct and steps the shared single-ALU / single-memory datapath through its phases: fetch, decode, execute/address, memory, writeback. It drives every datapath write-enable and mux select, and sits beside the PC, IR, register file and data/UART memory port inside the `mips` top.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (S_FETCH); not meant to be overridden except in debug builds.

Ports:
- clk  in  1  core clock
- rst_in  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in S_BR
- mem_ready  in  1  memory/UART port ready; used only with MIPS_MEM_WAIT_EN
- pc_wr  out  1  PC load enable
- ir_wr  out  1  IR load enable
- npc_op  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (jr)
- rf_wr  out  1  register-file write enable
- gpr_sel  out  2  write address: 0 = rt, 1 = rd, 2 = $31
- wd_sel  out  2  write data: 0 = ALU result, 1 = memory data, 2 = PC (return address)
- bsel  out  1  ALU B input: 0 = rt, 1 = extended immediate
- ext_op  out  2  0 = zero-extend, 1 = sign-extend, 2 = imm<<16
- alu_op  out  3  0 = add, 1 = sub, 2 = and, 3 = or, 4 = slt
- dm_wr  out  1  data-memory write enable
- illegal  out  1  one-cycle pulse on an unsupported instruction
- state_o  out  4  current state, for debug and LED display

Behaviour:
- Supported instructions: R-type (op 0x00) addu 0x21, subu 0x23, and 0x24, or 0x25, slt 0x2A, jr 0x08; addiu 0x09, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
- State is registered. Outputs are combinational from state, plus op/funct/zero where noted.
- States and encodings:
  - S_FETCH 0
  - S_DCD 1
  - S_MA 2
  - S_MR 3
  - S_MWB 4
  - S_MW 5
  - S_EXE 6
  - S_AWB 7
  - S_BR 8
  - S_JMP 9
- Transitions:
  - FETCH -> DCD.
  - DCD -> MA for lw/sw; EXE for R-ALU and immediate-ALU; BR for beq; JMP for j/jal/jr; FETCH with illegal = 1 otherwise.
  - MA -> MR for lw; MW for sw.
  - MR -> MWB.
  - MWB, MW, AWB, BR, JMP -> FETCH.
  - EXE -> AWB.
  - Unused encodings 10-15 -> FETCH.
- FETCH: pc_wr = 1, ir_wr = 1, npc_op = 0.
- DCD: all enables 0.
- MA: bsel = 1, ext_op = 1, alu_op = add.
- MW: dm_wr = 1.
- MWB: rf_wr = 1, gpr_sel = 0, wd_sel = 1.
- EXE: R-type uses bsel = 0 and alu_op from funct. addiu uses sign-extend/add; ori uses zero-extend/or; lui uses ext_op = 2 with add.
- AWB: rf_wr = 1, wd_sel = 0; gpr_sel = 1 for R-type, 0 for immediates.
- BR: alu_op = sub, bsel = 0, npc_op = 1, pc_wr = zero.
- JMP: pc_wr = 1; npc_op = 3 for jr, otherwise 2. For jal also rf_wr = 1, gpr_sel = 2, wd_sel = 2; the PC still holds PC+4 in this state.
- Latency, fetch to next fetch: ALU ops 4 cycles, lw 5, sw 4, beq/j/jal/jr 3, illegal 2.
- Reset: while rst_in = 0, state = S_FETCH and all enables (pc_wr, ir_wr, rf_wr, dm_wr, illegal) are 0. First fetch happens on the first rising clk edge after release.
- Reset asserted mid-instruction aborts immediately. No partial register-file or memory write may follow.
- Unused outputs in any state are 0. No delay slot.

Optional Feature:
- Macro: MIPS_MEM_WAIT_EN.
- Defined: FETCH, MR and MW each hold until mem_ready = 1.
  - pc_wr/ir_wr assert only in the FETCH cycle where mem_ready = 1.
  - dm_wr is held for every MW cycle. The state advances on mem_ready = 1.
  - Wait states add one cycle each to the latencies above.
- Undefined: mem_ready is ignored and each of these states lasts exactly one cycle.

Decomposition:
- Shared definitions file mips_ctrl_defs holds: opcode and funct constants, state encodings, and the npc_op, gpr_sel, wd_sel, ext_op and alu_op codes. The datapath muxes use the same file.
- One sub-module, mips_ctrl_decode (combinational), maps op/funct to an instruction class (RALU, IALU, LOAD, STORE, BEQ, JMP, JAL, JR, ILL) plus alu_op/ext_op.

Test Plan:
- Release reset, then feed addu (op 0x00, funct 0x21) -> states 0,1,6,7,0. In state 7, rf_wr = 1 and gpr_sel = 1; pc_wr pulses only in FETCH.
- lw (op 0x23) -> states 0,1,2,3,4,0 (5 cycles). MWB: rf_wr = 1, wd_sel = 1. sw (op 0x2B) -> dm_wr = 1 exactly one cycle, in state 5.
- beq (op 0x04) with zero = 1 -> state 8 has pc_wr = 1, npc_op = 1. With zero = 0 -> pc_wr = 0. Both return to FETCH after 3 cycles.
- jal (op 0x03) -> JMP asserts pc_wr = 1, npc_op = 2, rf_wr = 1, gpr_sel = 2, wd_sel = 2. jr (funct 0x08) -> npc_op = 3, rf_wr = 0.
- Opcode 0x3F -> illegal pulses for 1 cycle in DCD, then FETCH. Asserting rst_in = 0 during S_MW -> dm_wr drops to 0 immediately and state_o = 0.
- With MIPS_MEM_WAIT_EN and mem_ready held low 3 cycles in FETCH -> ir_wr = 0 during the wait, asserts for 1 cycle when mem_ready = 1, then state moves to DCD.
